// File: rtl/nine_segment_pkg.sv
// Shared types, legal patterns and pin-to-segment mapping
// for the six-pin (3x3 multiplexed) nine-segment die display.
package nine_segment_pkg;

  typedef logic [8:0] seg_t;

  localparam seg_t SEG_0 = 9'b000000000;
  localparam seg_t SEG_1 = 9'b000010000;
  localparam seg_t SEG_2 = 9'b100000001;
  localparam seg_t SEG_3 = 9'b100010001;
  localparam seg_t SEG_4 = 9'b101000101;
  localparam seg_t SEG_5 = 9'b101010101;
  localparam seg_t SEG_6 = 9'b111000111;
  localparam seg_t SEG_7 = 9'b111010111;

  // Column-major: segment index 3*col + row.
  function automatic logic [3:0] seg_idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return 4'(3 * c + r);
  endfunction

endpackage

// File: rtl/nine_segment_to_value.sv
// Pure combinational decode of a nine-segment die
// pattern to its value and a legality flag.
module nine_segment_to_value
  import nine_segment_pkg::*;
(
  input  logic [8:0] segments,
  output logic [2:0] value,
  output logic       value_ok
);

  always_comb begin
    value    = 3'd0;
    value_ok = 1'b1;
    unique case (1'b1)
      (segments == SEG_0): value = 3'd0;
      (segments == SEG_1): value = 3'd1;
      (segments == SEG_2): value = 3'd2;
      (segments == SEG_3): value = 3'd3;
      (segments == SEG_4): value = 3'd4;
      (segments == SEG_5): value = 3'd5;
      (segments == SEG_6): value = 3'd6;
      (segments == SEG_7): value = 3'd7;
      default: begin
        value    = 3'd0;
        value_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/six_pin_to_nine_segment.sv
// Frame-accumulating decoder for a 3x3 multiplexed display
// with a consecutive-frame stability filter on the output.
module six_pin_to_nine_segment
  import nine_segment_pkg::*;
#(
  parameter int FRAME_LEN     = 3,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rows,
  input  logic [2:0] cols,
  output logic [8:0] segments,
  output logic [2:0] value,
  output logic       value_ok,
  output logic       update
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [MW-1:0] SMAX = MW'(STABLE_FRAMES);
  localparam logic [MW-1:0] ONE  = MW'(1);

  seg_t          lit;
  seg_t          acc;
  seg_t          frame_pat;
  seg_t          prev_pat;
  logic [CW-1:0] cnt;
  logic [MW-1:0] match;
  logic [MW-1:0] match_nxt;
  logic          frame_new;
  logic          wrap;
  logic          load;

  always_comb begin
    lit = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        lit[seg_idx(2'(r), 2'(c))] = rows[r] & ~cols[c];
      end
    end
  end

  assign wrap = (cnt == LAST);

  // Frame compare runs one cycle after the frame closes.
  always_comb begin
    match_nxt = match;
    load      = 1'b0;
    if (frame_new) begin
      if (frame_pat == prev_pat) begin
        match_nxt = (match == SMAX) ? SMAX : match + ONE;
      end else begin
        match_nxt = ONE;
      end
      load = (match_nxt == SMAX) &&
             (frame_pat != segments);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      frame_pat <= '0;
      prev_pat  <= '0;
      frame_new <= 1'b0;
      match     <= '0;
      segments  <= '0;
      update    <= 1'b0;
    end else begin
      frame_new <= wrap;
      if (wrap) begin
        cnt       <= '0;
        acc       <= '0;
        frame_pat <= acc | lit;
      end else begin
        cnt <= cnt + 1'b1;
        acc <= acc | lit;
      end
      if (frame_new) begin
        prev_pat <= frame_pat;
        match    <= match_nxt;
      end
      update <= load;
      if (load) segments <= frame_pat;
    end
  end

  nine_segment_to_value u_dec (
    .segments (segments),
    .value    (value),
    .value_ok (value_ok)
  );

endmodule

// File: tb/tb_six_pin_to_nine_segment.sv
// Randomised and directed bench for six_pin_to_nine_segment,
// two instances (3/2 and 4/1) checked against a frame model.
module tb_six_pin_to_nine_segment;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rows  = 3'b000;
  logic [2:0] cols  = 3'b111;

  logic [8:0] seg0, seg1;
  logic [2:0] val0, val1;
  logic       ok0, ok1, upd0, upd1;

  six_pin_to_nine_segment u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rows     (rows),
    .cols     (cols),
    .segments (seg0),
    .value    (val0),
    .value_ok (ok0),
    .update   (upd0)
  );

  six_pin_to_nine_segment #(
    .FRAME_LEN     (4),
    .STABLE_FRAMES (1)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rows     (rows),
    .cols     (cols),
    .segments (seg1),
    .value    (val1),
    .value_ok (ok1),
    .update   (upd1)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] PAT [0:7] = '{
    9'b000000000, 9'b000010000, 9'b100000001, 9'b100010001,
    9'b101000101, 9'b101010101, 9'b111000111, 9'b111010111
  };

  int n_chk = 0;
  int n_err = 0;
  int ncyc  = 0;
  int upd_cnt0 = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frames of F cycles, output follows a pattern
  // once it has been seen in S consecutive frames.
  int         mf [2] = '{3, 4};
  int         ms [2] = '{2, 1};
  logic [8:0] m_acc [2];
  logic [8:0] m_last[2];
  logic [8:0] m_seg [2];
  logic [8:0] m_pend[2];
  int         m_phase[2];
  int         m_run  [2];
  logic       m_pv [2];
  logic       m_upd[2];

  function automatic logic [8:0] lit_of(input logic [2:0] r,
                                        input logic [2:0] c);
    logic [8:0] v;
    v = '0;
    for (int ci = 0; ci < 3; ci++)
      for (int ri = 0; ri < 3; ri++)
        if (r[ri] && !c[ci]) v[3*ci+ri] = 1'b1;
    return v;
  endfunction

  function automatic void model_rst();
    for (int i = 0; i < 2; i++) begin
      m_acc[i]   = '0;
      m_last[i]  = '0;
      m_seg[i]   = '0;
      m_pend[i]  = '0;
      m_phase[i] = 0;
      m_run[i]   = 0;
      m_pv[i]    = 1'b0;
      m_upd[i]   = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [2:0] r,
                                     input logic [2:0] c);
    logic [8:0] p;
    for (int i = 0; i < 2; i++) begin
      m_upd[i] = m_pv[i];
      if (m_pv[i]) m_seg[i] = m_pend[i];
      m_pv[i] = 1'b0;
      m_acc[i] = m_acc[i] | lit_of(r, c);
      m_phase[i]++;
      if (m_phase[i] == mf[i]) begin
        m_phase[i] = 0;
        p = m_acc[i];
        m_acc[i] = '0;
        m_run[i] = (p == m_last[i]) ? m_run[i] + 1 : 1;
        m_last[i] = p;
        if (m_run[i] >= ms[i] && p != m_seg[i]) begin
          m_pv[i]   = 1'b1;
          m_pend[i] = p;
        end
      end
    end
  endfunction

  function automatic logic [3:0] dec(input logic [8:0] s);
    for (int k = 0; k < 8; k++)
      if (s == PAT[k]) return {1'b1, 3'(k)};
    return 4'b0000;
  endfunction

  task automatic check_all();
    logic [3:0] d0, d1;
    d0 = dec(m_seg[0]);
    d1 = dec(m_seg[1]);
    chk("seg0", 32'(seg0), 32'(m_seg[0]));
    chk("val0", 32'(val0), 32'(d0[2:0]));
    chk("ok0",  32'(ok0),  32'(d0[3]));
    chk("upd0", 32'(upd0), 32'(m_upd[0]));
    chk("seg1", 32'(seg1), 32'(m_seg[1]));
    chk("val1", 32'(val1), 32'(d1[2:0]));
    chk("ok1",  32'(ok1),  32'(d1[3]));
    chk("upd1", 32'(upd1), 32'(m_upd[1]));
  endtask

  task automatic cyc(input logic [2:0] r, input logic [2:0] c);
    rows = r;
    cols = c;
    @(posedge clk);
    #1;
    model_step(r, c);
    ncyc++;
    check_all();
    if (upd0) upd_cnt0++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_rst();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n    = 1'b1;
    ncyc     = 0;
    upd_cnt0 = 0;
  endtask

  // Multiplexed drive sequence that lights die value v.
  function automatic logic [5:0] drv_state(input int v, input int i);
    case (v)
      0: return {3'b000, 3'b111};
      1: return {3'b010, 3'b101};
      2: return (i % 2 == 0) ? {3'b001, 3'b110} : {3'b100, 3'b011};
      3: begin
        case (i % 3)
          0: return {3'b100, 3'b011};
          1: return {3'b010, 3'b101};
          default: return {3'b001, 3'b110};
        endcase
      end
      4: return {3'b101, 3'b010};
      5: return (i % 2 == 0) ? {3'b101, 3'b010} : {3'b010, 3'b101};
      6: return {3'b111, 3'b010};
      default: return (i % 2 == 0) ? {3'b111, 3'b010}
                                   : {3'b010, 3'b101};
    endcase
  endfunction

  task automatic drive(input int v, input int n);
    logic [5:0] s;
    for (int i = 0; i < n; i++) begin
      s = drv_state(v, i);
      cyc(s[5:3], s[2:0]);
    end
  endtask

  initial begin
    logic [2:0] rr, cc;
    int         n;

    do_reset();
    chk("rst_seg", 32'(seg0), 32'h0);
    chk("rst_ok",  32'(ok0),  32'h1);

    // Loopback of pattern 3
    drive(3, 6);
    chk("p3_early", 32'(upd_cnt0), 32'd0);
    drive(3, 1);
    chk("p3_upd7", 32'(upd0), 32'h1);
    chk("p3_seg", 32'(seg0), 32'h111);
    chk("p3_val", 32'(val0), 32'd3);
    drive(3, 9);
    chk("p3_once", 32'(upd_cnt0), 32'd1);

    // Static drive of pattern 6
    upd_cnt0 = 0;
    drive(6, 15);
    chk("p6_seg", 32'(seg0), 32'h1c7);
    chk("p6_val", 32'(val0), 32'd6);
    chk("p6_once", 32'(upd_cnt0), 32'd1);

    // Illegal pattern
    upd_cnt0 = 0;
    for (int i = 0; i < 15; i++) cyc(3'b100, 3'b110);
    chk("ill_seg", 32'(seg0), 32'h004);
    chk("ill_val", 32'(val0), 32'd0);
    chk("ill_ok",  32'(ok0),  32'd0);
    chk("ill_once", 32'(upd_cnt0), 32'd1);

    // One-frame glitch of 7 inside a stable 5
    drive(5, 15);
    while (ncyc % 3 != 0) drive(5, 1);
    upd_cnt0 = 0;
    drive(7, 3);
    drive(5, 15);
    chk("gl_upd", 32'(upd_cnt0), 32'd0);
    chk("gl_seg", 32'(seg0), 32'h155);

    // Reset in the middle of a frame
    do_reset();
    drive(4, 10);
    chk("mr_pre", 32'(seg0), 32'h145);
    chk("mr_cnt", 32'(ncyc % 3), 32'd1);
    rst_n = 1'b0;
    #1;
    model_rst();
    chk("mr_seg", 32'(seg0), 32'h0);
    chk("mr_upd", 32'(upd0), 32'h0);
    chk("mr_ok",  32'(ok0),  32'h1);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    ncyc  = 0;
    drive(4, 6);
    chk("mr_wait", 32'(seg0), 32'h0);
    drive(4, 1);
    chk("mr_seg7", 32'(seg0), 32'h145);
    chk("mr_upd7", 32'(upd0), 32'h1);

    // Single-frame instance: pattern 2 appears at cycle 5
    do_reset();
    drive(2, 4);
    chk("pf_wait", 32'(seg1), 32'h0);
    drive(2, 1);
    chk("pf_upd5", 32'(upd1), 32'h1);
    chk("pf_seg",  32'(seg1), 32'h101);
    drive(7, 12);
    chk("pf_seg7", 32'(seg1), 32'h1d7);

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0: do_reset();
        1, 2, 3: begin
          rr = 3'($urandom);
          cc = 3'($urandom);
          n  = $urandom_range(1, 8);
          for (int i = 0; i < n; i++) cyc(rr, cc);
        end
        default: drive($urandom_range(0, 7),
                       $urandom_range(1, 12));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
